// File: rtl/run_ctrl_pkg.sv
// Shared types and helpers for the CPU run-control block.
// State encoding and the rate-select width derived from the divider width.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        STEP_IDLE = 2'd1,
        STEP_ARM  = 2'd2,
        HALTED    = 2'd3
    } run_state_t;

    // Bits needed to select any divider bit; never narrower than one bit.
    function automatic int rate_sel_w(input int div_w);
        return (div_w > 1) ? $clog2(div_w) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-FF synchroniser -> stable-level filter -> one-cycle rising-edge pulse.
// Latency from raw level change to pulse is 2 + DEBOUNCE_CYCLES + 1 cycles; no backpressure.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             level;
    logic             level_q;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a     <= 1'b0;
            sync_b     <= 1'b0;
            level      <= 1'b0;
            level_q    <= 1'b0;
            stable_cnt <= '0;
            pulse      <= 1'b0;
        end else begin
            sync_a  <= btn;
            sync_b  <= sync_a;
            level_q <= level;
            pulse   <= level & ~level_q;
            // Any sample agreeing with the accepted level restarts the run of differing samples.
            if (sync_b == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                level      <= sync_b;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run control for the pipelined CPU: rate divider, halt-on-match, single step, enabled-cycle count.
// cpu_en is a one-cycle clock-enable pulse decided combinationally from state and tick; no backpressure.
module cpu_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int                DIV_W           = 24,
    parameter int                DATA_W          = 32,
    parameter logic [DATA_W-1:0] HALT_VALUE      = 32'h0000000d,
    parameter int                DEBOUNCE_CYCLES = 16,
    parameter int                CYC_W           = 32,
    localparam int               RS_W            = rate_sel_w(DIV_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RS_W-1:0]   rate_sel,
    input  logic              step_mode,
    input  logic              step_btn,
    input  logic              resume_btn,
    input  logic              halt_en,
    input  logic [DATA_W-1:0] watch_val,
    output logic              cpu_en,
    output logic              halted,
    output logic [CYC_W-1:0]  cycle_count,
    output logic              heartbeat
);

    localparam logic [RS_W-1:0] RATE_MAX = RS_W'(DIV_W - 1);

    run_state_t       state;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] mask;
    logic [RS_W-1:0]  rate_eff;
    logic             tick;
    logic             halt_armed;
    logic             match;
    logic             step_pulse;
    logic             resume_pulse;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clk   (clk),
        .reset (reset),
        .btn   (step_btn),
        .pulse (step_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_resume_db (
        .clk   (clk),
        .reset (reset),
        .btn   (resume_btn),
        .pulse (resume_pulse)
    );

    // Selects beyond the top divider bit fall back to the slowest real rate.
    always_comb begin
        rate_eff = rate_sel;
        if (int'(rate_sel) >= DIV_W) begin
            rate_eff = RATE_MAX;
        end
    end

    always_comb begin
        mask      = (DIV_W'(1) << rate_eff) - DIV_W'(1);
        tick      = ((div_cnt & mask) == mask);
        heartbeat = div_cnt[rate_eff];
        match     = halt_en & halt_armed & (watch_val == HALT_VALUE);
    end

    always_comb begin
        cpu_en = 1'b0;
        if (!reset && (state == RUN || state == STEP_ARM)) begin
            cpu_en = tick & ~match;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt     <= '0;
            cycle_count <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            if (cpu_en && (cycle_count != {CYC_W{1'b1}})) begin
                cycle_count <= cycle_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            halted     <= 1'b0;
            halt_armed <= 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (match) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (step_mode) begin
                        state <= STEP_IDLE;
                    end
                end
                STEP_IDLE: begin
                    if (step_pulse) begin
                        state <= STEP_ARM;
                    end else if (!step_mode) begin
                        state <= RUN;
                    end
                end
                // An armed step always finishes (or halts) before step_mode is looked at again.
                STEP_ARM: begin
                    if (match) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (tick) begin
                        state <= STEP_IDLE;
                    end
                end
                HALTED: begin
                    if (resume_pulse) begin
                        state  <= step_mode ? STEP_IDLE : RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase

            // Disarm on resume so a still-matching value does not re-halt; re-arm once it moves away.
            if (state == HALTED && resume_pulse) begin
                halt_armed <= 1'b0;
            end else if (watch_val != HALT_VALUE) begin
                halt_armed <= 1'b1;
            end
        end
    end

endmodule
